// File: rtl/bist_pkg.sv
// Shared types and helpers for the logic-BIST wrapper.
package bist_pkg;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] TAP_MASK = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  // Feedback bit of x^8+x^6+x^5+x^4+1, shared by LFSR and MISR
  function automatic logic fb(input logic [WIDTH-1:0] x);
    return ^(x & TAP_MASK);
  endfunction

endpackage

// File: rtl/bist_if.sv
// Tester-facing BIST handshake: start request, end and pass status.
interface bist_if;
  logic bist_start;
  logic bist_end;
  logic pass_nfail;

  modport master (output bist_start, input bist_end, input pass_nfail);
  modport slave  (input bist_start, output bist_end, output pass_nfail);
endinterface

// File: rtl/bist_cut.sv
// Combinational circuit-under-test; BIST_FAULT_INJECT_EN forces output bit 0 stuck-at-0.
module bist_cut
  import bist_pkg::*;
(
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] good;

  assign good[3:0] = 4'(in_i[3:0] + in_i[7:4]);
  assign good[7:4] = in_i[7:4] ^ ~in_i[3:0];

`ifdef BIST_FAULT_INJECT_EN
  assign out_o = {good[WIDTH-1:1], 1'b0};
`else
  assign out_o = good;
`endif

endmodule

// File: rtl/bist_top.sv
// Logic-BIST wrapper: LFSR patterns drive the CUT, a MISR compacts responses,
// and the controller compares the final signature against GOLDEN_SIG.
module bist_top
  import bist_pkg::*;
#(
  parameter int unsigned      N_PATTERNS = 6,
  parameter logic [WIDTH-1:0] LFSR_SEED  = 8'h01,
  parameter logic [WIDTH-1:0] GOLDEN_SIG = 8'h4A
) (
  input  logic  clk,
  input  logic  reset,
  bist_if.slave bus
);

  localparam logic [7:0] LAST_CNT = 8'(N_PATTERNS - 1);

  bist_state_e      state_q, state_d;
  logic             start_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] misr_q, misr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] cut_out;
  logic             start_pulse;

  assign start_pulse = bus.bist_start & ~start_q;

  bist_cut u_cut (
    .in_i  (lfsr_q),
    .out_o (cut_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.bist_start;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and datapath update; DONE restarts exactly like IDLE
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_pulse) begin
          state_d = RUN;
          lfsr_d  = LFSR_SEED;
          misr_d  = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        misr_d = {misr_q[WIDTH-2:0], fb(misr_q)} ^ cut_out;
        lfsr_d = {lfsr_q[WIDTH-2:0], fb(lfsr_q)};
        cnt_d  = 8'(cnt_q + 8'd1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          pass_d  = (misr_d == GOLDEN_SIG);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bist_end   = (state_q == DONE);
  assign bus.pass_nfail = pass_q & (state_q == DONE);

endmodule

// File: tb/tb_bist_top.sv
// Directed bench for bist_top: latency, signature, restart, hold-high and reset abort.
module tb_bist_top;

`ifdef BIST_FAULT_INJECT_EN
  localparam logic [7:0] EXP_SIG  = 8'h68;
  localparam logic       EXP_PASS = 1'b0;
`else
  localparam logic [7:0] EXP_SIG  = 8'h4A;
  localparam logic       EXP_PASS = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bist_if bus ();
  bist_if bus_bad ();

  assign bus_bad.bist_start = bus.bist_start;

  bist_top dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Same run against a golden value that can never match
  bist_top #(.GOLDEN_SIG(8'h00)) dut_bad (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_bad.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start, detect at edge k, expect bist_end exactly after edge k+6
  task automatic run_check(input string tag, input bit hold);
    bus.bist_start = 1'b1;
    tick();
    if (!hold) bus.bist_start = 1'b0;
    check({tag, "_end_k"}, 32'(bus.bist_end), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("%s_end_c%0d", tag, i), 32'(bus.bist_end), 32'(i == 6));
    end
    check({tag, "_pass"}, 32'(bus.pass_nfail), 32'(EXP_PASS));
    check({tag, "_misr"}, 32'(dut.misr_q), 32'(EXP_SIG));
    check({tag, "_bad_end"}, 32'(bus_bad.bist_end), 32'd1);
    check({tag, "_bad_pass"}, 32'(bus_bad.pass_nfail), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.bist_start = 1'b0;
    tick();
    tick();
    check("rst_end", 32'(bus.bist_end), 32'd0);
    check("rst_pass", 32'(bus.pass_nfail), 32'd0);
    check("rst_misr", 32'(dut.misr_q), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr_q), 32'h01);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_end", 32'(bus.bist_end), 32'd0);
      check("idle_pass", 32'(bus.pass_nfail), 32'd0);
    end

    run_check("pulse", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_hold_end", 32'(bus.bist_end), 32'd1);
    end

    // Second rising edge in DONE reruns; keep start high through and after the run
    run_check("rerun_hold", 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("no_retrig_end", 32'(bus.bist_end), 32'd1);
      check("no_retrig_misr", 32'(dut.misr_q), 32'(EXP_SIG));
    end
    bus.bist_start = 1'b0;
    tick();
    check("drop_start_end", 32'(bus.bist_end), 32'd1);

    // Reset while in DONE clears outputs without waiting for a clock
    #2;
    reset = 1'b1;
    #1;
    check("rst_done_end", 32'(bus.bist_end), 32'd0);
    check("rst_done_pass", 32'(bus.pass_nfail), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Abort a run at its third cycle
    bus.bist_start = 1'b1;
    tick();
    bus.bist_start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_run_end", 32'(bus.bist_end), 32'd0);
    check("mid_run_cnt", 32'(dut.cnt_q), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("abort_end", 32'(bus.bist_end), 32'd0);
    check("abort_pass", 32'(bus.pass_nfail), 32'd0);
    check("abort_misr", 32'(dut.misr_q), 32'd0);
    check("abort_cnt", 32'(dut.cnt_q), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_abort_idle", 32'(bus.bist_end), 32'd0);
    end

    run_check("after_abort", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
